// File: rtl/lmi_cache_fill_sm.sv
// Cache line fill controller: invalidate sweep, miss fill (wrap/linear burst), uncached fetch, RAM grant.
// Fill request one cycle after miss detect; fill_req held until fill_ack; done one cycle after last beat.
module lmi_cache_fill_sm #(
  parameter int LINE_WORDS = 4,
  parameter int NSETS      = 64,
  parameter int ADDR_W     = 32,
  parameter int WRAP_EN    = 1
) (
  input  logic                          SYSCLK,
  input  logic                          RESET_N,
  input  logic                          req_valid,
  input  logic [ADDR_W-1:0]             req_addr,
  input  logic                          hit,
  input  logic                          uncached,
  input  logic                          bus_busy,
  input  logic                          inval_req,
  input  logic                          ram_req,
  input  logic                          fill_ack,
  input  logic                          data_valid,
  input  logic                          data_err,
  output logic                          fill_req,
  output logic [ADDR_W-1:0]             fill_addr,
  output logic                          fill_single,
  output logic                          wr_en,
  output logic [$clog2(LINE_WORDS)-1:0] wr_word,
  output logic                          tag_wr,
  output logic                          inv_en,
  output logic [$clog2(NSETS)-1:0]      inv_idx,
  output logic                          uc_valid,
  output logic                          err,
  output logic                          ram_gnt,
  output logic                          stall,
  output logic                          done,
  output logic [2:0]                    state_o
);

  localparam int CW = $clog2(LINE_WORDS);
  localparam int SW = $clog2(NSETS);
  localparam logic [ADDR_W-1:0] WORD_MASK = ~ADDR_W'(3);
  localparam logic [ADDR_W-1:0] LINE_MASK = ~ADDR_W'((2 ** (CW + 2)) - 1);

  typedef enum logic [2:0] {
    S_INIT   = 3'd0,
    S_LOOKUP = 3'd1,
    S_REQ    = 3'd2,
    S_FILL   = 3'd3,
    S_UCWAIT = 3'd4,
    S_WB     = 3'd5,
    S_GNTRAM = 3'd6
  } state_t;

  state_t            state_q, state_d;
  logic [SW-1:0]     sweep_q, sweep_d;
  logic [CW-1:0]     ptr_q, ptr_d;
  logic [CW-1:0]     beat_q, beat_d;
  logic              pend_q, pend_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              unc_q, unc_d;
  logic              miss;

  assign miss    = req_valid & ~hit;
  assign state_o = state_q;

  always_ff @(posedge SYSCLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q <= S_INIT;
      sweep_q <= '0;
      ptr_q   <= '0;
      beat_q  <= '0;
      pend_q  <= 1'b0;
      addr_q  <= '0;
      unc_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      sweep_q <= sweep_d;
      ptr_q   <= ptr_d;
      beat_q  <= beat_d;
      pend_q  <= pend_d;
      addr_q  <= addr_d;
      unc_q   <= unc_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    sweep_d     = sweep_q;
    ptr_d       = ptr_q;
    beat_d      = beat_q;
    pend_d      = pend_q | inval_req;
    addr_d      = addr_q;
    unc_d       = unc_q;
    fill_req    = 1'b0;
    fill_addr   = '0;
    fill_single = 1'b0;
    wr_en       = 1'b0;
    wr_word     = ptr_q;
    tag_wr      = 1'b0;
    inv_en      = 1'b0;
    inv_idx     = sweep_q;
    uc_valid    = 1'b0;
    err         = 1'b0;
    ram_gnt     = 1'b0;
    stall       = 1'b1;
    done        = 1'b0;

    case (state_q)
      S_INIT: begin
        inv_en  = 1'b1;
        sweep_d = sweep_q + SW'(1);
        if (sweep_q == SW'(NSETS - 1)) state_d = S_LOOKUP;
      end
      S_LOOKUP: begin
        stall  = miss;
        pend_d = pend_q;
        // Invalidate wins over everything; the pending flag is consumed on INIT entry.
        if (pend_q | inval_req) begin
          state_d = S_INIT;
          sweep_d = '0;
          pend_d  = 1'b0;
        end else if (ram_req & ~miss) begin
          state_d = S_GNTRAM;
        end else if (miss & ~bus_busy) begin
          state_d = S_REQ;
          addr_d  = req_addr;
          unc_d   = uncached;
        end
      end
      S_REQ: begin
        fill_req    = 1'b1;
        fill_single = unc_q;
        fill_addr   = (unc_q || (WRAP_EN != 0)) ? (addr_q & WORD_MASK) : (addr_q & LINE_MASK);
        if (fill_ack) begin
          state_d = unc_q ? S_UCWAIT : S_FILL;
          ptr_d   = (WRAP_EN != 0) ? addr_q[CW+1:2] : '0;
          beat_d  = '0;
        end
      end
      S_FILL: begin
        if (data_valid) begin
          if (data_err) begin
            err     = 1'b1;
            state_d = S_WB;
          end else begin
            wr_en  = 1'b1;
            ptr_d  = ptr_q + CW'(1);
            beat_d = beat_q + CW'(1);
            if (beat_q == CW'(LINE_WORDS - 1)) begin
              tag_wr  = 1'b1;
              state_d = S_WB;
            end
          end
        end
      end
      S_UCWAIT: begin
        if (data_valid) begin
          uc_valid = 1'b1;
          err      = data_err;
          state_d  = S_WB;
        end
      end
      S_WB: begin
        done    = 1'b1;
        state_d = S_LOOKUP;
      end
      S_GNTRAM: begin
        ram_gnt = ram_req;
        if (!ram_req) state_d = S_WB;
      end
      default: begin
        state_d = S_INIT;
        sweep_d = '0;
      end
    endcase
  end

endmodule

// File: doc/lmi_cache_fill_sm.md
LMI_CACHE_FILL_SM -- requirements
Module: lmi_cache_fill_sm

Interface
REQ-001 Parameter LINE_WORDS, 4: words per line; power of 2, 2..16; CW = log2(LINE_WORDS).
REQ-002 Parameter NSETS, 64: sets swept on invalidate; power of 2; SW = log2(NSETS).
REQ-003 Parameter ADDR_W, 32: fill address width.
REQ-004 Parameter WRAP_EN, 1: 1 = critical-word-first wrap burst; 0 = burst from word 0.
REQ-005 SYSCLK  in  1  sole clock; all state changes on its rising edge.
REQ-006 RESET_N  in  1  asynchronous active-low reset.
REQ-007 Request inputs: req_valid in 1 (fetch lookup active); req_addr in ADDR_W; hit in 1; uncached in 1.
REQ-008 Arbitration inputs: bus_busy in 1 (other unit owns bus); inval_req in 1 (invalidate all); ram_req in 1 (external RAM access).
REQ-009 Bus inputs: fill_ack in 1 (request accepted); data_valid in 1 (beat present); data_err in 1 (beat error, qualified by data_valid).
REQ-010 Fill outputs: fill_req out 1; fill_addr out ADDR_W; fill_single out 1.
REQ-011 Array outputs: wr_en out 1; wr_word out CW; tag_wr out 1; inv_en out 1; inv_idx out SW.
REQ-012 Status outputs: uc_valid, err, ram_gnt, stall, done, each out 1; state_o out 3.

Function
REQ-013 States, state_o code: INIT 0, LOOKUP 1, REQ 2, FILL 3, UCWAIT 4, WB 5, GNTRAM 6; codes 7 and undefined recover to INIT.
REQ-014 INIT: inv_en=1, inv_idx=sweep counter; counter +1 per cycle; at NSETS-1 go to LOOKUP; total NSETS cycles.
REQ-015 LOOKUP priority:
- inval pending -> INIT, sweep counter 0
- else ram_req with no miss (~(req_valid & ~hit)) -> GNTRAM
- else req_valid & ~hit & ~bus_busy -> REQ; capture req_addr and uncached
- else stay
REQ-016 Miss with bus_busy=1: stay in LOOKUP, retry each cycle.
REQ-017 inval_req outside LOOKUP sets a sticky pending flag; flag clears on INIT entry; fill in progress is never aborted.
REQ-018 REQ: fill_req=1 held until fill_ack (no timeout); on fill_ack -> UCWAIT if captured uncached, else FILL.
REQ-019 fill_addr while REQ:
- uncached: captured word address, bits[1:0]=0
- cached, WRAP_EN=1: captured address, bits[1:0]=0
- cached, WRAP_EN=0: line-aligned, bits[CW+1:0]=0
REQ-020 fill_single=captured uncached, valid while fill_req=1.
REQ-021 FILL entry: word pointer = captured addr[CW+1:2] (WRAP_EN=1) or 0; beat counter = 0.
REQ-022 FILL, data_valid & ~data_err: wr_en=1, wr_word=pointer; pointer +1 modulo LINE_WORDS (wraps); beat +1.
REQ-023 FILL, beat LINE_WORDS-1 written: tag_wr=1 that cycle, next WB.
REQ-024 FILL, data_valid & data_err: wr_en=0, tag_wr=0, err=1 one cycle, next WB; beats after abort are ignored.
REQ-025 UCWAIT, data_valid: uc_valid=1 one cycle (err=data_err), next WB; never writes arrays.
REQ-026 WB: done=1 for one cycle, next LOOKUP.
REQ-027 GNTRAM: ram_gnt=1 while ram_req=1; ram_req=0 -> WB.
REQ-028 stall=1 in every state except LOOKUP; in LOOKUP stall = req_valid & ~hit.
REQ-029 All pulse outputs (wr_en, tag_wr, inv_en, uc_valid, err, done) are combinational from state/inputs and glitch-free at the clock edge.
REQ-030 Latency, cached miss: LOOKUP detect -> fill_req next cycle; done exactly one cycle after last beat.

Reset
REQ-031 RESET_N low immediately forces: state INIT; sweep, pointer, beat counters 0; pending flag 0; captured registers 0.
REQ-032 During reset: fill_req, ram_gnt, wr_en, tag_wr, err, uc_valid, done = 0; stall=1; state_o=0.
REQ-033 Mid-operation reset abandons the fill with no tag_wr; after release a full NSETS-cycle sweep runs before LOOKUP.

Verification
REQ-034 Reset release, NSETS=4: inv_en high 4 cycles, inv_idx 0,1,2,3; state_o=1 on cycle 5.
REQ-035 Cached miss, LINE_WORDS=4, WRAP_EN=1, req_addr=0x108, fill_ack, 4 clean beats: fill_addr=0x108; wr_word 2,3,0,1; tag_wr on 4th beat; done next cycle.
REQ-036 Same miss, data_err on beat 2: wr_word 2 only; err=1 on beat 2; tag_wr never 1; WB then LOOKUP.
REQ-037 Uncached miss at 0x204, bus_busy=1 for 3 cycles: fill_req only after bus_busy falls; fill_single=1; uc_valid one cycle; no wr_en.
REQ-038 inval_req pulsed during FILL: fill completes with tag_wr; WB -> LOOKUP -> INIT sweep.
REQ-039 ram_req=1 in LOOKUP with hit: GNTRAM, ram_gnt=1 for 5 cycles; ram_req drops -> WB, done=1 -> LOOKUP.
